// File: rtl/rcm_pkg.sv
// rcm_pkg: command word layout, free marker, unpack helper, FSM states and entry classes
package rcm_pkg;
   localparam int W      = 338;
   localparam int TS_MSB = 337, TS_LSB = 274;
   localparam int FQ_MSB = 273, FQ_LSB = 226;
   localparam int FS_MSB = 225, FS_LSB = 178;
   localparam int FR_MSB = 177, FR_LSB = 146;
   localparam int NI_MSB = 145, NI_LSB = 130;
   localparam int TY_MSB = 129, TY_LSB = 128;
   localparam int TI_MSB = 127, TI_LSB = 96;
   localparam int TP_MSB = 95,  TP_LSB = 64;
   localparam int B1_MSB = 63,  B1_LSB = 32;
   localparam int B2_MSB = 31,  B2_LSB = 0;
   localparam logic [63:0] FREE_TIME = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct packed {
      logic [63:0] time_start;
      logic [47:0] freq;
      logic [47:0] freq_step;
      logic [31:0] freq_rate;
      logic [15:0] n_impulse;
      logic [1:0]  type_impulse;
      logic [31:0] interval_ti;
      logic [31:0] interval_tp;
      logic [31:0] tblank1;
      logic [31:0] tblank2;
   } cmd_word_t;

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_CHECK, S_OUT, S_CLR} state_t;
   typedef enum logic [1:0] {C_FREE, C_STALE, C_DUE, C_FUTURE} cls_t;

   function automatic cmd_word_t unpack_cmd(input logic [W-1:0] w);
      cmd_word_t c;
      c.time_start   = w[TS_MSB:TS_LSB];
      c.freq         = w[FQ_MSB:FQ_LSB];
      c.freq_step    = w[FS_MSB:FS_LSB];
      c.freq_rate    = w[FR_MSB:FR_LSB];
      c.n_impulse    = w[NI_MSB:NI_LSB];
      c.type_impulse = w[TY_MSB:TY_LSB];
      c.interval_ti  = w[TI_MSB:TI_LSB];
      c.interval_tp  = w[TP_MSB:TP_LSB];
      c.tblank1      = w[B1_MSB:B1_LSB];
      c.tblank2      = w[B2_MSB:B2_LSB];
      return c;
   endfunction
endpackage

// File: rtl/rcm_time_cmp.sv
// rcm_time_cmp: classifies an entry's start time against now and the dispatch window
module rcm_time_cmp
   import rcm_pkg::*;
#(
   parameter logic [63:0] LEAD = 64'd1000
) (
   input  logic [63:0] time_start,
   input  logic [63:0] time_now,
   output cls_t        cls
);
   logic [64:0] win_end;
   assign win_end = {1'b0, time_now} + {1'b0, LEAD};
   // free marker wins, then past, then inside the window; 65-bit end avoids wrap near max time
   always_comb
      cls = time_start == FREE_TIME        ? C_FREE  :
            time_start < time_now          ? C_STALE :
            {1'b0, time_start} <= win_end  ? C_DUE   : C_FUTURE;
endmodule

// File: rtl/rcm.sv
// rcm: scans the command memory, dispatches due commands, counts stale ones, requests clears
module rcm
   import rcm_pkg::*;
#(
   parameter int          N_IDX  = 255,
   parameter int          RD_LAT = 1,
   parameter logic [63:0] LEAD   = 64'd1000
) (
   input  logic          CLK,
   input  logic          rst,
   input  logic          ENABLE,
   input  logic [63:0]   TIME_NOW,
   output logic          RD_REG,
   output logic [7:0]    rd_REG_ADDR,
   input  logic [337:0]  MEM_Q,
   output logic          CLR_REQ,
   output logic [7:0]    CLR_ADDR,
   input  logic          CLR_ACK,
   output logic          CMD_VALID,
   input  logic          CMD_READY,
   output logic [47:0]   FREQ,
   output logic [47:0]   FREQ_STEP,
   output logic [31:0]   FREQ_RATE,
   output logic [63:0]   TIME_START,
   output logic [15:0]   N_impulse,
   output logic [1:0]    TYPE_impulse,
   output logic [31:0]   Interval_Ti,
   output logic [31:0]   Interval_Tp,
   output logic [31:0]   Tblank1,
   output logic [31:0]   Tblank2,
   output logic          BUSY,
   output logic [15:0]   STALE_CNT
);
   state_t    state, state_nx;
   cls_t      cls;
   cmd_word_t cw, f;
   logic [7:0] addr, addr_nx;
   logic [1:0] wcnt;
   logic       adv;

   assign cw = unpack_cmd(MEM_Q);

   rcm_time_cmp #(.LEAD(LEAD)) u_cmp (
      .time_start (cw.time_start),
      .time_now   (TIME_NOW),
      .cls        (cls)
   );

   assign addr_nx = addr == 8'(N_IDX) ? 8'd0 : addr + 8'd1;
   assign adv     = (state == S_CHECK && (cls == C_FREE || cls == C_FUTURE)) || (state == S_CLR && CLR_ACK);

   // state register
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // next-state: OUT and CLR always run to completion, ENABLE only gates the next read
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  state_nx = ENABLE ? S_RD : S_IDLE;
         S_RD:    state_nx = S_WAIT;
         S_WAIT:  state_nx = wcnt == 2'(RD_LAT - 1) ? S_CHECK : S_WAIT;
         S_CHECK: state_nx = cls == C_DUE ? S_OUT : cls == C_STALE ? S_CLR : ENABLE ? S_RD : S_IDLE;
         S_OUT:   state_nx = CMD_READY ? S_CLR : S_OUT;
         S_CLR:   state_nx = CLR_ACK ? (ENABLE ? S_RD : S_IDLE) : S_CLR;
         default: state_nx = S_IDLE;
      endcase
   end

   // strobes decoded from the state register only, so no input reaches an output
   always_comb begin
      RD_REG    = state == S_RD;
      CMD_VALID = state == S_OUT;
      CLR_REQ   = state == S_CLR;
      BUSY      = state != S_IDLE;
   end

   assign rd_REG_ADDR = addr;
   assign CLR_ADDR    = addr;

   // scan position, read-latency counter, stale counter and captured command fields
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         addr      <= '0;
         wcnt      <= '0;
         STALE_CNT <= '0;
         f         <= '0;
      end else begin
         if (adv) addr <= addr_nx;
         wcnt <= state == S_WAIT ? wcnt + 2'd1 : 2'd0;
         if (state == S_CHECK && cls == C_STALE && STALE_CNT != 16'hFFFF) STALE_CNT <= STALE_CNT + 16'd1;
         if (state == S_CHECK && cls == C_DUE) f <= cw;
      end
   end

   assign TIME_START   = f.time_start;
   assign FREQ         = f.freq;
   assign FREQ_STEP    = f.freq_step;
   assign FREQ_RATE    = f.freq_rate;
   assign N_impulse    = f.n_impulse;
   assign TYPE_impulse = f.type_impulse;
   assign Interval_Ti  = f.interval_ti;
   assign Interval_Tp  = f.interval_tp;
   assign Tblank1      = f.tblank1;
   assign Tblank2      = f.tblank2;
endmodule
